// File: rtl/alu_op_decode_queue.sv
// alu_op_decode_queue
//   Registered RV32I ALU-op decoder feeding a DEPTH-entry FIFO. Each accepted instruction is
//   translated into an ALU op code plus an illegal flag. It is queued together with a sideband
//   tag (PC / ROB id) and presented at the head with a valid/ready handshake.
//
//   Optional feature macro: RV32M_EN. When defined, OP with funct7=0x01 decodes to
//   {2'b10, funct3} (MUL..REMU) and ALU_OP_W must be 5. When undefined, those encodings
//   are illegal.
//
// Ports
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   flush              synchronous queue clear (illegal_cnt is kept)
//   in_valid/in_ready  upstream handshake; in_ready = !full && !flush
//   in_instr, in_tag   instruction word and sideband tag
//   out_valid/out_ready downstream handshake on the queue head
//   out_alu_op, out_illegal, out_tag  head entry (hold last head while empty)
//   illegal_cnt        saturating count of accepted illegal instructions
module alu_op_decode_queue #(
    parameter int unsigned ALU_OP_W = 4,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned TAG_W    = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                out_illegal,
    output logic [TAG_W-1:0]    out_tag,
    output logic [CNT_W-1:0]    illegal_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = ALU_OP_W + 1 + TAG_W;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_SLTU = 5'b01100;
    localparam logic [4:0] OP_SLT  = 5'b01101;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   OCC_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   OCC_MAX = (PW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] IC_ONE = CNT_W'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
`ifdef RV32M_EN
    if (ALU_OP_W != 5) begin : g_bad_op_w
        $error("ALU_OP_W must be 5 when RV32M_EN is defined");
    end
`endif

    // Register-register mapping of funct3; OP-IMM reuses it with shift tweaks.
    function automatic logic [4:0] f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_op = OP_ADD;
            3'b001:  f3_op = OP_SLL;
            3'b010:  f3_op = OP_SLT;
            3'b011:  f3_op = OP_SLTU;
            3'b100:  f3_op = OP_XOR;
            3'b101:  f3_op = OP_SRL;
            3'b110:  f3_op = OP_OR;
            default: f3_op = OP_AND;
        endcase
    endfunction

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] dec_op;
    logic       dec_ill;
    logic       unused_instr;

    assign opc          = in_instr[6:2];
    assign f3           = in_instr[14:12];
    assign f7           = in_instr[31:25];
    assign unused_instr = ^{in_instr[24:15], in_instr[11:7]};

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (opc)
            5'h04: begin
                dec_op = f3_op(f3);
                if (f3 == 3'b001) begin
                    dec_ill = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'h20) dec_op = OP_SRA;
                    else if (f7 != 7'h00) dec_ill = 1'b1;
                end
            end
            5'h0C: begin
                case (f7)
                    7'h00: dec_op = f3_op(f3);
                    7'h20: begin
                        if (f3 == 3'b000) dec_op = OP_SUB;
                        else if (f3 == 3'b101) dec_op = OP_SRA;
                        else dec_ill = 1'b1;
                    end
`ifdef RV32M_EN
                    7'h01: dec_op = {2'b10, f3};
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            5'h18: begin
                case (f3[2:1])
                    2'b00:   dec_op = OP_SUB;
                    2'b10:   dec_op = OP_SLT;
                    2'b11:   dec_op = OP_SLTU;
                    default: dec_ill = 1'b1;
                endcase
            end
            5'h00, 5'h08, 5'h0D, 5'h05, 5'h1B, 5'h19: dec_op = OP_ADD;
            default: dec_ill = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) dec_ill = 1'b1;
        if (dec_ill) dec_op = OP_ADD;
    end

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]      occ_q, occ_d;
    logic [EW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty, full, push, pop;
    logic [EW-1:0]    head;

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OCC_MAX);
    assign in_ready  = !full && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign head      = mem_q[rptr_q];

    // While empty the outputs show the last head that was presented.
    assign {out_alu_op, out_illegal, out_tag} = empty ? hold_q : head;
    assign illegal_cnt = cnt_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        hold_d = empty ? hold_q : head;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_ONE;
            if (pop)  rptr_d = rptr_q + PTR_ONE;
            if (push && !pop) occ_d = occ_q + OCC_ONE;
            else if (pop && !push) occ_d = occ_q - OCC_ONE;
        end
        // push is already blocked during flush, so the count is never lost to it.
        if (push && dec_ill && cnt_q != '1) cnt_d = cnt_q + IC_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage needs no reset: it is only observed through occ_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {ALU_OP_W'(dec_op), dec_ill, in_tag};
    end

endmodule

// File: tb/tb_alu_op_decode_queue.sv
module tb_alu_op_decode_queue;

`ifdef RV32M_EN
    localparam int unsigned AW = 5;
    localparam bit M_EN = 1'b1;
`else
    localparam int unsigned AW = 4;
    localparam bit M_EN = 1'b0;
`endif
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 32;
    localparam int unsigned CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // funct3 -> op code for register-register ops
    localparam int F3_OP [8] = '{0, 4, 13, 12, 11, 6, 10, 9};

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [AW-1:0]    out_alu_op;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] illegal_cnt;

    alu_op_decode_queue #(
        .ALU_OP_W(AW),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu_op (out_alu_op),
        .out_illegal(out_illegal),
        .out_tag    (out_tag),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        bit          ill;
        logic [31:0] tag;
    } ent_t;

    ent_t mq[$];
    ent_t last;
    int   ref_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder written from the instruction-set rules on full 7-bit opcodes.
    function automatic ent_t ref_decode(input logic [31:0] i, input logic [31:0] tag);
        ent_t e;
        int opc = int'(i[6:0]);
        int f3  = int'(i[14:12]);
        int f7  = int'(i[31:25]);
        e.ill = 1'b1;
        e.op  = 0;
        e.tag = tag;
        if (opc == 'h13) begin
            e.ill = 1'b0;
            e.op  = F3_OP[f3];
            if (f3 == 1 && f7 != 0) e.ill = 1'b1;
            if (f3 == 5) begin
                if (f7 == 'h20) e.op = 7;
                else if (f7 != 0) e.ill = 1'b1;
            end
        end else if (opc == 'h33) begin
            if (f7 == 0) begin
                e.ill = 1'b0; e.op = F3_OP[f3];
            end else if (f7 == 'h20 && f3 == 0) begin
                e.ill = 1'b0; e.op = 1;
            end else if (f7 == 'h20 && f3 == 5) begin
                e.ill = 1'b0; e.op = 7;
            end else if (f7 == 1 && M_EN) begin
                e.ill = 1'b0; e.op = 16 + f3;
            end
        end else if (opc == 'h63) begin
            if (f3 < 2) begin e.ill = 1'b0; e.op = 1; end
            else if (f3 >= 6) begin e.ill = 1'b0; e.op = 12; end
            else if (f3 >= 4) begin e.ill = 1'b0; e.op = 13; end
        end else if (opc == 'h03 || opc == 'h23 || opc == 'h37 || opc == 'h17 ||
                     opc == 'h6F || opc == 'h67) begin
            e.ill = 1'b0;
        end
        if (e.ill) e.op = 0;
        return e;
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic ordy, input logic fl);
        ent_t h;
        ent_t e;
        bit   exp_ready, push, pop;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        exp_ready = (mq.size() < DEPTH) && !fl;
        h = (mq.size() != 0) ? mq[0] : last;
        check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check_eq("out_alu_op", 64'(out_alu_op), 64'(h.op));
        check_eq("out_illegal", 64'(out_illegal), 64'(h.ill));
        check_eq("out_tag", 64'(out_tag), 64'(h.tag));
        check_eq("illegal_cnt", 64'(illegal_cnt), 64'(ref_cnt));
        push = v && exp_ready;
        pop  = (mq.size() != 0) && ordy && !fl;
        if (mq.size() != 0) last = mq[0];
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e = ref_decode(ins, tg);
                mq.push_back(e);
                if (e.ill && ref_cnt < CNT_MAX) ref_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear immediately.
    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        reset_n  = 1'b0;
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_alu_op", 64'(out_alu_op), 64'd0);
        check_eq("rst_illegal", 64'(out_illegal), 64'd0);
        check_eq("rst_tag", 64'(out_tag), 64'd0);
        check_eq("rst_cnt", 64'(illegal_cnt), 64'd0);
        mq.delete();
        last    = '{op: 0, ill: 1'b0, tag: 32'h0};
        ref_cnt = 0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        logic [6:0]  f7;
        r = $urandom;
        case ($urandom_range(0, 10))
            0, 1:    opc = 7'h13;
            2, 3:    opc = 7'h33;
            4:       opc = 7'h63;
            5:       opc = 7'h03;
            6:       opc = 7'h23;
            7:       opc = 7'h37;
            8:       opc = 7'h6F;
            9:       opc = 7'h67;
            default: opc = 7'(r[6:0]);
        endcase
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = r[31:25];
        endcase
        if ($urandom_range(0, 15) == 0) opc[1:0] = 2'($urandom_range(0, 2));
        return {f7, r[24:7], opc};
    endfunction

    initial begin
        last    = '{op: 0, ill: 1'b0, tag: 32'h0};
        ref_cnt = 0;
        #22;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0);

        // sub, then srai and addi with instr[30] set
        step(1'b1, 32'h4020_8033, 32'h100, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b1, 32'h4050_D093, 32'h104, 1'b1, 1'b0);
        step(1'b1, 32'h4000_0093, 32'h108, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // all-ones and all-zeros words are illegal
        step(1'b1, 32'hFFFF_FFFF, 32'h200, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0000, 32'h204, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // fill past capacity with the consumer stalled, then drain in order
        for (int k = 0; k <= DEPTH; k++) step(1'b1, 32'h0020_8033 + 32'(k << 12),
                                               32'h300 + 32'(k), 1'b0, 1'b0);
        for (int k = 0; k <= DEPTH; k++) idle(1'b1);

        // flush while full with a push attempt
        for (int k = 0; k < DEPTH; k++) step(1'b1, 32'h0000_0013, 32'h400 + 32'(k), 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 32'h4FF, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // mul: M-extension op when enabled, illegal otherwise
        step(1'b1, 32'h0220_8033, 32'h500, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // drive the illegal counter into saturation
        for (int k = 0; k < CNT_MAX + 3; k++) step(1'b1, 32'h0000_0007, 32'(k), 1'b1, 1'b0);
        idle(1'b1);

        do_reset();
        idle(1'b1);

        // randomized traffic with occasional flush and mid-stream resets
        for (int k = 0; k < 600; k++) begin
            if (k % 200 == 199) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
                     1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
            end
        end
        for (int k = 0; k < DEPTH + 1; k++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
